rename_stage: RTL and testbench

Register-rename stage between decode and dispatch. It consumes `decode_pkg::decoded_t` bundles and produces `decode_pkg::renamed_t` bundles:
- architectural rs1/rs2/rd are mapped to physical registers through a speculative register alias table (RAT);
- destinations get fresh physical registers from a circular free list;
- the previous mapping is reported as `old_rd`.

A commit port keeps a committed RAT and recycles old mappings. Flush restores speculative state from committed state.

---
 rtl/decode_pkg.sv | 47 ++++
 rtl/rename_stage_if.sv | 41 ++++
 rtl/rename_stage.sv | 149 ++++++++++++++
 tb/tb_rename_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: bundle types shared by decode, rename and dispatch.
//   decoded_t : decoder output; register fields are 6 bits wide, and only
//               [4:0] name an architectural register.
//   renamed_t : rename output; rs1/rs2/rd/old_rd name physical registers.
package decode_pkg;

    typedef enum logic [2:0] {
        UOP_ALU    = 3'd0,
        UOP_LOAD   = 3'd1,
        UOP_STORE  = 3'd2,
        UOP_BRANCH = 3'd3,
        UOP_JUMP   = 3'd4,
        UOP_CSR    = 3'd5,
        UOP_SYSTEM = 3'd6,
        UOP_NOP    = 3'd7
    } uop_e;

    typedef struct packed {
        logic [31:0] pc;
        uop_e        uop;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] csr_addr;
        logic        csr_imm_valid;
        logic        illegal;
    } decoded_t;

    typedef struct packed {
        logic [31:0] pc;
        uop_e        uop;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [5:0]  old_rd;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] csr_addr;
        logic        csr_imm_valid;
        logic        illegal;
    } renamed_t;

endpackage

// File: rtl/rename_stage_if.sv
// rename_stage_if: all non-clock signals of the rename stage.
//   in_*      : decode -> rename bundle handshake
//   out_*     : rename -> dispatch bundle handshake
//   commit_*  : in-order retirement of allocating instructions
//   flush_i   : squash all uncommitted state
//   free_count_o : free-list occupancy (debug / perf counters)
// Handshake: a bundle moves on a rising clock edge where valid && ready;
// the sender holds valid and data stable until then, and ready never
// depends on valid in the same direction.
// Modports: slave = the rename stage, master = its environment.
interface rename_stage_if;
    import decode_pkg::*;

    logic       in_valid_i;
    logic       in_ready_o;
    decoded_t   in_data_i;
    logic       out_valid_o;
    logic       out_ready_i;
    renamed_t   out_data_o;
    logic       commit_valid_i;
    logic [4:0] commit_arch_rd_i;
    logic [5:0] commit_preg_i;
    logic [5:0] commit_old_preg_i;
    logic       flush_i;
    logic [5:0] free_count_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        input  commit_valid_i, commit_arch_rd_i, commit_preg_i, commit_old_preg_i,
        input  flush_i,
        output in_ready_o, out_valid_o, out_data_o, free_count_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        output commit_valid_i, commit_arch_rd_i, commit_preg_i, commit_old_preg_i,
        output flush_i,
        input  in_ready_o, out_valid_o, out_data_o, free_count_o
    );

endinterface

// File: rtl/rename_stage.sv
// rename_stage: register rename between decode and dispatch.
//   Maps rs1/rs2 through the speculative RAT, gives each allocating
//   destination a fresh physical register from a circular free list and
//   reports the displaced mapping as old_rd. Retirement updates the
//   committed RAT and recycles old_rd; flush copies committed state back.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : rename_stage_if.slave (in/out handshakes, commit, flush,
//                  free_count_o)
// Optional feature: define RENAME_FREE_BYPASS_EN to let an allocation take
//   commit_old_preg_i directly when the free list is empty.
module rename_stage
    import decode_pkg::*;
#(
    parameter int NUM_AREGS = 32,
    parameter int NUM_PREGS = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rename_stage_if.slave bus
);

    localparam int AW       = $clog2(NUM_AREGS);
    localparam int PW       = $clog2(NUM_PREGS);
    localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int FW       = $clog2(FL_DEPTH);
    localparam logic [PW-1:0] FL_FULL = PW'(FL_DEPTH);

    logic [PW-1:0] spec_rat   [NUM_AREGS];
    logic [PW-1:0] commit_rat [NUM_AREGS];
    logic [PW-1:0] free_list  [FL_DEPTH];
    logic [FW-1:0] head;
    logic [FW-1:0] tail;
    logic [FW-1:0] commit_head;
    logic [PW-1:0] count;

    logic     out_valid_q;
    renamed_t out_data_q;
    renamed_t renamed;

    logic          alloc;
    logic          accept;
    logic          alloc_fire;
    logic          free_avail;
    logic          take_bypass;
    logic [PW-1:0] new_preg;
    logic [AW-1:0] rd_arch;

    // Upper register-field bits carry no architectural meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.in_data_i.rs1[5], bus.in_data_i.rs2[5], bus.in_data_i.rd[5]};

`ifdef RENAME_FREE_BYPASS_EN
    // An empty list can still serve an allocation with the entry being
    // returned this very cycle.
    assign free_avail  = (count != '0) || bus.commit_valid_i;
    assign take_bypass = (count == '0);
`else
    assign free_avail  = (count != '0);
    assign take_bypass = 1'b0;
`endif

    assign rd_arch    = bus.in_data_i.rd[AW-1:0];
    assign alloc      = (bus.in_data_i.uop inside {UOP_ALU, UOP_LOAD, UOP_JUMP, UOP_CSR})
                        && (rd_arch != '0);
    // Conservative: does not look at the incoming bundle.
    assign bus.in_ready_o = !bus.flush_i && (!out_valid_q || bus.out_ready_i) && free_avail;
    assign accept     = bus.in_valid_i && bus.in_ready_o;
    assign alloc_fire = accept && alloc;
    assign new_preg   = take_bypass ? bus.commit_old_preg_i : free_list[head];

    always_comb begin
        renamed               = '0;
        renamed.pc            = bus.in_data_i.pc;
        renamed.uop           = bus.in_data_i.uop;
        renamed.imm           = bus.in_data_i.imm;
        renamed.funct3        = bus.in_data_i.funct3;
        renamed.funct7        = bus.in_data_i.funct7;
        renamed.csr_addr      = bus.in_data_i.csr_addr;
        renamed.csr_imm_valid = bus.in_data_i.csr_imm_valid;
        renamed.illegal       = bus.in_data_i.illegal;
        renamed.rs1           = spec_rat[bus.in_data_i.rs1[AW-1:0]];
        renamed.rs2           = spec_rat[bus.in_data_i.rs2[AW-1:0]];
        if (alloc) begin
            renamed.rd     = new_preg;
            renamed.old_rd = spec_rat[rd_arch];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                spec_rat[i]   <= PW'(i);
                commit_rat[i] <= PW'(i);
            end
            for (int k = 0; k < FL_DEPTH; k++) begin
                free_list[k] <= PW'(NUM_AREGS + k);
            end
            head        <= '0;
            tail        <= '0;
            commit_head <= '0;
            count       <= FL_FULL;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (bus.commit_valid_i) begin
                if (bus.commit_arch_rd_i != '0) begin
                    commit_rat[bus.commit_arch_rd_i] <= bus.commit_preg_i;
                end
                free_list[tail] <= bus.commit_old_preg_i;
                tail            <= tail + 1'b1;
                commit_head     <= commit_head + 1'b1;
            end

            if (bus.flush_i) begin
                // Restore from the committed view as it stands after this
                // cycle's commit. tail tracks commit_head, so the list is
                // full again.
                for (int i = 0; i < NUM_AREGS; i++) begin
                    if (bus.commit_valid_i && (bus.commit_arch_rd_i == AW'(i)) && (i != 0)) begin
                        spec_rat[i] <= bus.commit_preg_i;
                    end else begin
                        spec_rat[i] <= commit_rat[i];
                    end
                end
                head        <= commit_head + FW'(bus.commit_valid_i);
                count       <= FL_FULL;
                out_valid_q <= 1'b0;
            end else begin
                if (alloc_fire) begin
                    spec_rat[rd_arch] <= new_preg;
                    head              <= head + 1'b1;
                end
                count <= count + PW'(bus.commit_valid_i) - PW'(alloc_fire);
                if (accept) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= renamed;
                end else if (bus.out_ready_i) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_data_o   = out_data_q;
    assign bus.free_count_o = count;

endmodule

// File: tb/tb_rename_stage.sv
module tb_rename_stage;
    import decode_pkg::*;

    localparam int RW = $bits(renamed_t);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rename_stage_if bus();

    rename_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // ---------------- reference model ----------------
    // RATs as plain arrays, free registers as a FIFO queue, allocations not
    // yet committed as a second queue (they return to the front on flush).
    logic [5:0]    m_spec   [32];
    logic [5:0]    m_commit [32];
    logic [5:0]    free_q   [$];
    logic [5:0]    inflight [$];
    logic [RW-1:0] exp_q    [$];

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_spec[i]   = 6'(i);
            m_commit[i] = 6'(i);
        end
        free_q.delete();
        for (int k = 0; k < 32; k++) free_q.push_back(6'(32 + k));
        inflight.delete();
        exp_q.delete();
    endfunction

    function automatic bit model_ready();
        bit have_free;
        have_free = (free_q.size() != 0);
`ifdef RENAME_FREE_BYPASS_EN
        have_free = have_free || bus.commit_valid_i;
`endif
        return !bus.flush_i && (exp_q.size() == 0 || bus.out_ready_i) && have_free;
    endfunction

    task automatic model_step();
        decoded_t   d;
        renamed_t   r;
        logic [5:0] preg;
        bit         bypassed;
        bit         needs_reg;
        bypassed = 1'b0;
        d = bus.in_data_i;
        if (bus.in_valid_i && model_ready()) begin
            r = '0;
            r.pc = d.pc;             r.uop = d.uop;         r.imm = d.imm;
            r.funct3 = d.funct3;     r.funct7 = d.funct7;   r.csr_addr = d.csr_addr;
            r.csr_imm_valid = d.csr_imm_valid;              r.illegal = d.illegal;
            r.rs1 = m_spec[d.rs1[4:0]];
            r.rs2 = m_spec[d.rs2[4:0]];
            needs_reg = (d.uop == UOP_ALU || d.uop == UOP_LOAD || d.uop == UOP_JUMP ||
                         d.uop == UOP_CSR) && (d.rd[4:0] != 5'd0);
            if (needs_reg) begin
                if (free_q.size() == 0) begin
                    preg = bus.commit_old_preg_i;
                    bypassed = 1'b1;
                end else begin
                    preg = free_q.pop_front();
                end
                r.rd = preg;
                r.old_rd = m_spec[d.rd[4:0]];
                m_spec[d.rd[4:0]] = preg;
                inflight.push_back(preg);
            end
            exp_q.push_back(r);
        end
        if (bus.commit_valid_i) begin
            if (bus.commit_arch_rd_i != 5'd0) m_commit[bus.commit_arch_rd_i] = bus.commit_preg_i;
            if (inflight.size() != 0) void'(inflight.pop_front());
            if (!bypassed) free_q.push_back(bus.commit_old_preg_i);
        end
        if (bus.flush_i) begin
            m_spec = m_commit;
            for (int i = inflight.size() - 1; i >= 0; i--) free_q.push_front(inflight[i]);
            inflight.delete();
            exp_q.delete();
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Compare process: every cycle out of reset, mid-cycle.
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("in_ready", 128'(bus.in_ready_o), 128'(model_ready()));
            chk("free_count", 128'(bus.free_count_o), 128'(free_q.size()));
            chk("out_valid", 128'(bus.out_valid_o), 128'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_data", 128'(bus.out_data_o), 128'(exp_q[0]));
                if (bus.out_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    function automatic decoded_t mk(input uop_e u, input int rd, input int rs1, input int rs2, input bit ill);
        decoded_t d;
        d = '0;
        d.pc            = $urandom;
        d.uop           = u;
        d.rd            = {1'($urandom_range(0, 1)), 5'(rd)};
        d.rs1           = {1'($urandom_range(0, 1)), 5'(rs1)};
        d.rs2           = {1'($urandom_range(0, 1)), 5'(rs2)};
        d.imm           = $urandom;
        d.funct3        = 3'($urandom_range(0, 7));
        d.funct7        = 7'($urandom_range(0, 127));
        d.csr_addr      = 12'($urandom_range(0, 4095));
        d.csr_imm_valid = 1'($urandom_range(0, 1));
        d.illegal       = ill;
        return d;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input decoded_t d);
        int n;
        n = 0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        @(negedge clk);
        while (!bus.in_ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready_o stayed 0 for %0d cycles at %0t", n, $time);
        end
        cycle();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic commit(input int ard, input int preg, input int old);
        bus.commit_valid_i    = 1'b1;
        bus.commit_arch_rd_i  = 5'(ard);
        bus.commit_preg_i     = 6'(preg);
        bus.commit_old_preg_i = 6'(old);
    endtask

    uop_e tab_uop [8] = '{UOP_LOAD, UOP_JUMP, UOP_CSR, UOP_BRANCH, UOP_ALU, UOP_ALU, UOP_CSR, UOP_SYSTEM};
    int   tab_rd  [8] = '{3, 1, 2, 9, 4, 3, 0, 7};
    int   tab_rs1 [8] = '{5, 0, 3, 5, 1, 3, 2, 6};
    int   tab_rs2 [8] = '{0, 0, 0, 6, 2, 3, 0, 6};
    bit   tab_ill [8] = '{0, 0, 0, 0, 1, 0, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        bus.in_valid_i = 1'b0;
        bus.in_data_i = '0;
        bus.out_ready_i = 1'b1;
        bus.commit_valid_i = 1'b0;
        bus.commit_arch_rd_i = '0;
        bus.commit_preg_i = '0;
        bus.commit_old_preg_i = '0;
        bus.flush_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;

        // Reset state
        chk("rst_free_count", 128'(bus.free_count_o), 128'(32));
        chk("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready_o), 128'(1));

        // ADD x5 <- x1, x2
        send(mk(UOP_ALU, 5, 1, 2, 0));
        chk("add_rs1", 128'(bus.out_data_o.rs1), 128'(1));
        chk("add_rs2", 128'(bus.out_data_o.rs2), 128'(2));
        chk("add_rd", 128'(bus.out_data_o.rd), 128'(32));
        chk("add_old_rd", 128'(bus.out_data_o.old_rd), 128'(5));
        chk("add_free_count", 128'(bus.free_count_o), 128'(31));

        // SUB x6 <- x5, x5 back-to-back
        send(mk(UOP_ALU, 6, 5, 5, 0));
        chk("sub_rs1", 128'(bus.out_data_o.rs1), 128'(32));
        chk("sub_rs2", 128'(bus.out_data_o.rs2), 128'(32));
        chk("sub_rd", 128'(bus.out_data_o.rd), 128'(33));
        chk("sub_old_rd", 128'(bus.out_data_o.old_rd), 128'(6));

        // STORE and ADD x0: no allocation
        send(mk(UOP_STORE, 7, 6, 5, 0));
        chk("store_rs1", 128'(bus.out_data_o.rs1), 128'(33));
        chk("store_rd", 128'(bus.out_data_o.rd), 128'(0));
        chk("store_old_rd", 128'(bus.out_data_o.old_rd), 128'(0));
        send(mk(UOP_ALU, 0, 0, 6, 0));
        chk("addx0_rs1", 128'(bus.out_data_o.rs1), 128'(0));
        chk("addx0_rd", 128'(bus.out_data_o.rd), 128'(0));
        chk("addx0_old_rd", 128'(bus.out_data_o.old_rd), 128'(0));
        chk("addx0_free_count", 128'(bus.free_count_o), 128'(30));

        // Mixed uops, with dispatch pausing now and then
        for (int i = 0; i < 8; i++) begin
            send(mk(tab_uop[i], tab_rd[i], tab_rs1[i], tab_rs2[i], tab_ill[i]));
            if (i % 3 == 0) begin
                bus.out_ready_i = 1'b0;
                cycle();
                cycle();
                bus.out_ready_i = 1'b1;
            end
        end
        cycle();

        // Dispatch stall
        do_reset();
        bus.out_ready_i = 1'b0;
        send(mk(UOP_ALU, 11, 1, 2, 0));
        bus.in_valid_i = 1'b1;
        bus.in_data_i = mk(UOP_ALU, 12, 11, 11, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_out_valid", 128'(bus.out_valid_o), 128'(1));
            chk("stall_rd", 128'(bus.out_data_o.rd), 128'(32));
            chk("stall_old_rd", 128'(bus.out_data_o.old_rd), 128'(11));
            chk("stall_in_ready", 128'(bus.in_ready_o), 128'(0));
            chk("stall_free_count", 128'(bus.free_count_o), 128'(31));
        end
        bus.out_ready_i = 1'b1;
        send(bus.in_data_i);
        chk("after_stall_rs1", 128'(bus.out_data_o.rs1), 128'(32));
        chk("after_stall_rd", 128'(bus.out_data_o.rd), 128'(33));

        // Asynchronous reset mid-operation
        bus.in_valid_i = 1'b1;
        bus.in_data_i = mk(UOP_ALU, 13, 1, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_free_count", 128'(bus.free_count_o), 128'(32));
        chk("async_rst_out_valid", 128'(bus.out_valid_o), 128'(0));
        bus.in_valid_i = 1'b0;
        cycle();
        rst = 1'b0;

        // Exhaust the free list
        for (int i = 0; i < 32; i++) begin
            send(mk(UOP_ALU, (i == 0) ? 5 : (i % 31) + 1, i % 32, (i * 7) % 32, 0));
        end
        bus.in_valid_i = 1'b1;
        bus.in_data_i = mk(UOP_ALU, 10, 10, 0, 0);
        @(negedge clk);
        chk("empty_in_ready", 128'(bus.in_ready_o), 128'(0));
        chk("empty_free_count", 128'(bus.free_count_o), 128'(0));
        cycle();
        commit(5, 32, 5);
`ifdef RENAME_FREE_BYPASS_EN
        @(negedge clk);
        chk("bypass_in_ready", 128'(bus.in_ready_o), 128'(1));
        cycle();
        bus.commit_valid_i = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("bypass_rd", 128'(bus.out_data_o.rd), 128'(5));
        chk("bypass_free_count", 128'(bus.free_count_o), 128'(0));
`else
        cycle();
        bus.commit_valid_i = 1'b0;
        chk("recycle_free_count", 128'(bus.free_count_o), 128'(1));
        cycle();
        bus.in_valid_i = 1'b0;
        chk("recycle_rd", 128'(bus.out_data_o.rd), 128'(5));
        chk("recycle_free_count_after", 128'(bus.free_count_o), 128'(0));
`endif
        chk("recycle_old_rd", 128'(bus.out_data_o.old_rd), 128'(41));
        cycle();

        // Flush restores committed state
        do_reset();
        send(mk(UOP_ALU, 5, 1, 1, 0));
        send(mk(UOP_LOAD, 7, 2, 0, 0));
        commit(5, 32, 5);
        cycle();
        bus.commit_valid_i = 1'b0;
        bus.flush_i = 1'b1;
        cycle();
        bus.flush_i = 1'b0;
        chk("flush_free_count", 128'(bus.free_count_o), 128'(32));
        chk("flush_out_valid", 128'(bus.out_valid_o), 128'(0));
        send(mk(UOP_STORE, 0, 5, 7, 0));
        chk("flush_x5", 128'(bus.out_data_o.rs1), 128'(32));
        chk("flush_x7", 128'(bus.out_data_o.rs2), 128'(7));
        send(mk(UOP_ALU, 8, 7, 5, 0));
        chk("flush_next_rd", 128'(bus.out_data_o.rd), 128'(33));
        send(mk(UOP_ALU, 9, 8, 8, 0));
        chk("flush_x9_rd", 128'(bus.out_data_o.rd), 128'(34));

        // Flush together with a commit in the same cycle
        commit(8, 33, 8);
        bus.flush_i = 1'b1;
        cycle();
        bus.commit_valid_i = 1'b0;
        bus.flush_i = 1'b0;
        send(mk(UOP_STORE, 0, 8, 9, 0));
        chk("flush_commit_x8", 128'(bus.out_data_o.rs1), 128'(33));
        chk("flush_commit_x9", 128'(bus.out_data_o.rs2), 128'(9));
        send(mk(UOP_ALU, 1, 5, 0, 0));
        chk("flush_commit_rd", 128'(bus.out_data_o.rd), 128'(34));
        chk("flush_commit_rs1", 128'(bus.out_data_o.rs1), 128'(32));
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
